// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaled centisecond counter with start/stop, clear, test load and lap hold.
// Lap feature (LAP state, snapshot register) is compiled in only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV  = 1000000,
    parameter logic [31:0] MAX_COUNT = 32'd599999
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    input  logic [31:0] test_value,
    input  logic        apply_test_value,
    output logic [31:0] count_value,
    output logic [31:0] display_value,
    output logic [1:0]  state,
    output logic        running,
    output logic        lap_active,
    output logic        wrap_pulse
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

`ifdef STOPWATCH_LAP_EN
    localparam logic LAP_EN = 1'b1;
`else
    localparam logic LAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    state_t               state_q;
    logic [31:0]          count_q;
    logic [PRESC_W-1:0]   presc_q;
    logic                 wrap_q;
`ifdef STOPWATCH_LAP_EN
    logic [31:0]          lap_q;
`endif

    logic        active;
    logic        tick;
    logic        lap_ev;
    logic [31:0] load_val;

    assign active   = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick     = active && (presc_q == PRESC_LAST);
    // With the lap feature disabled this is constant 0, so LAP can never be entered.
    assign lap_ev   = btn_lap & LAP_EN;
    assign load_val = (test_value > MAX_COUNT) ? MAX_COUNT : test_value;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            presc_q <= '0;
            wrap_q  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_q   <= '0;
`endif
        end else begin
            wrap_q <= 1'b0;
            if (btn_clear) begin
                state_q <= ST_IDLE;
                count_q <= '0;
                presc_q <= '0;
`ifdef STOPWATCH_LAP_EN
                lap_q   <= '0;
`endif
            end else if (apply_test_value) begin
                count_q <= load_val;
                presc_q <= '0;
                if (state_q == ST_LAP) begin
                    state_q <= ST_RUN;
                end
            end else begin
                // Prescaler runs on the current state, so the cycle that pauses still advances it.
                if (active) begin
                    if (tick) begin
                        presc_q <= '0;
                        if (count_q == MAX_COUNT) begin
                            count_q <= '0;
                            wrap_q  <= 1'b1;
                        end else begin
                            count_q <= count_q + 32'd1;
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                case (state_q)
                    ST_IDLE: begin
                        if (btn_start_stop) state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (btn_start_stop) begin
                            state_q <= ST_PAUSE;
                        end else if (lap_ev) begin
                            state_q <= ST_LAP;
`ifdef STOPWATCH_LAP_EN
                            lap_q   <= count_q;
`endif
                        end
                    end
                    ST_LAP: begin
                        if (btn_start_stop) begin
                            state_q <= ST_PAUSE;
                        end else if (lap_ev) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_PAUSE: begin
                        if (btn_start_stop) state_q <= ST_RUN;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign count_value = count_q;
    assign state       = state_q;
    assign running     = active;
    assign wrap_pulse  = wrap_q;
`ifdef STOPWATCH_LAP_EN
    assign lap_active    = (state_q == ST_LAP);
    assign display_value = (state_q == ST_LAP) ? lap_q : count_q;
`else
    assign lap_active    = 1'b0;
    assign display_value = count_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with TICK_DIV=4, MAX_COUNT=9.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        btn_start_stop;
    logic        btn_lap;
    logic        btn_clear;
    logic [31:0] test_value;
    logic        apply_test_value;
    logic [31:0] count_value;
    logic [31:0] display_value;
    logic [1:0]  state;
    logic        running;
    logic        lap_active;
    logic        wrap_pulse;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    stopwatch_ctrl #(
        .TICK_DIV  (4),
        .MAX_COUNT (32'd9)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .btn_start_stop   (btn_start_stop),
        .btn_lap          (btn_lap),
        .btn_clear        (btn_clear),
        .test_value       (test_value),
        .apply_test_value (apply_test_value),
        .count_value      (count_value),
        .display_value    (display_value),
        .state            (state),
        .running          (running),
        .lap_active       (lap_active),
        .wrap_pulse       (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %-16s got=%0d exp=%0d ok", tag, got, exp);
        end else begin
            $display("FAIL %-16s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns so outputs are sampled away from the edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] v);
        test_value = v;
        apply_test_value = 1'b1;
        cycles(1);
        apply_test_value = 1'b0;
    endtask

    task automatic start_stop();
        btn_start_stop = 1'b1;
        cycles(1);
        btn_start_stop = 1'b0;
    endtask

    task automatic lap();
        btn_lap = 1'b1;
        cycles(1);
        btn_lap = 1'b0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_count"}, count_value, 0);
        chk({pfx, "_disp"},  display_value, 0);
        chk({pfx, "_state"}, 32'(state), 0);
        chk({pfx, "_run"},   32'(running), 0);
        chk({pfx, "_lapact"}, 32'(lap_active), 0);
        chk({pfx, "_wrap"},  32'(wrap_pulse), 0);
    endtask

    initial begin
        resetn = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap = 1'b0;
        btn_clear = 1'b0;
        test_value = '0;
        apply_test_value = 1'b0;
        @(negedge clk);
        cycles(2);
        resetn = 1'b1;
        chk_all_zero("rst");

        // Start from IDLE: first increment exactly 4 cycles after entering RUN.
        start_stop();
        chk("start_state", 32'(state), 1);
        cycles(3);
        chk("pre_tick_cnt", count_value, 0);
        cycles(1);
        chk("first_tick_cnt", count_value, 1);
        cycles(8);
        chk("run12_cnt", count_value, 3);
        chk("run12_state", 32'(state), 1);
        chk("run12_running", 32'(running), 1);

        // Load MAX, wrap after one prescaler period.
        apply(32'd9);
        chk("load9_cnt", count_value, 9);
        cycles(3);
        chk("prewrap_cnt", count_value, 9);
        chk("prewrap_wrap", 32'(wrap_pulse), 0);
        cycles(1);
        chk("wrap_cnt", count_value, 0);
        chk("wrap_pulse", 32'(wrap_pulse), 1);
        chk("wrap_state", 32'(state), 1);
        cycles(1);
        chk("wrap_one_cyc", 32'(wrap_pulse), 0);

        apply(32'd5);
`ifdef STOPWATCH_LAP_EN
        lap();
        chk("lap_state", 32'(state), 3);
        chk("lap_active", 32'(lap_active), 1);
        chk("lap_running", 32'(running), 1);
        chk("lap_disp", display_value, 5);
        cycles(8);
        chk("lap8_disp", display_value, 5);
        chk("lap8_cnt", count_value, 7);
        lap();
        chk("unlap_disp", display_value, 7);
        chk("unlap_lapact", 32'(lap_active), 0);
        chk("unlap_state", 32'(state), 1);
`else
        lap();
        chk("nolap_state", 32'(state), 1);
        chk("nolap_lapact", 32'(lap_active), 0);
        chk("nolap_disp", display_value, 5);
        cycles(8);
        chk("nolap8_cnt", count_value, 7);
        chk("nolap8_disp", display_value, 7);
        chk("nolap8_state", 32'(state), 1);
`endif

        // Clear outranks start_stop.
        btn_clear = 1'b1;
        btn_start_stop = 1'b1;
        cycles(1);
        btn_clear = 1'b0;
        btn_start_stop = 1'b0;
        chk("clr_state", 32'(state), 0);
        chk("clr_cnt", count_value, 0);
        cycles(5);
        chk("idle_hold_cnt", count_value, 0);

        // Pause, clamp load, hold, resume from held prescaler.
        start_stop();
        start_stop();
        chk("pause_state", 32'(state), 2);
        chk("pause_running", 32'(running), 0);
        apply(32'd20);
        chk("clamp_cnt", count_value, 9);
        chk("clamp_state", 32'(state), 2);
        cycles(6);
        chk("pause_hold_cnt", count_value, 9);
        start_stop();
        chk("resume_state", 32'(state), 1);
        cycles(3);
        chk("resume3_cnt", count_value, 9);
        cycles(1);
        chk("resume_wrap_cnt", count_value, 0);
        chk("resume_wrap", 32'(wrap_pulse), 1);

        // apply outranks start_stop; start_stop outranks lap.
        test_value = 32'd2;
        apply_test_value = 1'b1;
        btn_start_stop = 1'b1;
        cycles(1);
        apply_test_value = 1'b0;
        btn_start_stop = 1'b0;
        chk("prio_apply_cnt", count_value, 2);
        chk("prio_apply_st", 32'(state), 1);
        btn_start_stop = 1'b1;
        btn_lap = 1'b1;
        cycles(1);
        btn_start_stop = 1'b0;
        btn_lap = 1'b0;
        chk("prio_ss_lap_st", 32'(state), 2);

        // Reset overrides events mid-LAP (mid-RUN without the lap feature).
        start_stop();
`ifdef STOPWATCH_LAP_EN
        lap();
        chk("prerst_state", 32'(state), 3);
`else
        chk("prerst_state", 32'(state), 1);
`endif
        cycles(2);
        resetn = 1'b0;
        btn_start_stop = 1'b1;
        btn_lap = 1'b1;
        cycles(1);
        resetn = 1'b1;
        btn_start_stop = 1'b0;
        btn_lap = 1'b0;
        chk_all_zero("midrst");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
